// File: rtl/bus_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter8
//  Purpose  : Round-robin controller sharing one 16-bit output bus between
//             eight requesters. The granted word is steered through an
//             8-way, 16-bit mux tree. The grant is a one-hot decode of the
//             registered select. Words move with a valid/ready handshake,
//             and each grant carries at most MAX_BURST words.
//  Ports    :
//    clock      in   1   rising-edge clock
//    reset      in   1   asynchronous, active-high reset
//    req        in   8   per-requester request
//    last       in   8   requester i marks its current word as final
//    in0..in7   in  16   requester data words
//    gnt        out  8   one-hot grant (registered), zero when idle
//    sel        out  3   index of granted requester (registered)
//    out        out 16   in[sel] while BUSY, 16'h0000 otherwise
//    out_valid  out  1   BUSY and req[sel]
//    out_ready  in   1   consumer accepts the word
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter8 #(
    parameter int MAX_BURST = 4     // legal range 1..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [7:0]  last,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    input  logic [15:0] in5,
    input  logic [15:0] in6,
    input  logic [15:0] in7,
    output logic [7:0]  gnt,
    output logic [2:0]  sel,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    // Count is wide enough to hold MAX_BURST itself; release happens at
    // equality so it never wraps.
    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        r_state;
    logic [7:0]    r_gnt;
    logic [2:0]    r_sel;
    logic [2:0]    r_ptr;
    logic [CW-1:0] r_count;

    logic [2:0]    w_pick;
    logic          w_found;
    logic [7:0]    w_dec;
    logic          w_busy;
    logic          w_valid;
    logic          w_xfer;
    logic          w_final;
    logic [CW-1:0] w_count_inc;

    logic [15:0]   w_lvl0 [8];
    logic [15:0]   w_lvl1 [4];
    logic [15:0]   w_lvl2 [2];
    logic [15:0]   w_mux;

    // ------------------------------------------------------------------
    // Round-robin scan: start one above the last granted index and take
    // the first set request bit. The 3-bit sum wraps naturally, and the
    // eighth step lands back on ptr so the previous owner comes last.
    // ------------------------------------------------------------------
    always_comb begin
        logic [2:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        v_idx   = r_ptr;
        for (int i = 1; i <= 8; i++) begin
            v_idx = r_ptr + 3'(i);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // One-hot decode of the chosen index; registered into gnt at grant time
    // so gnt and sel always describe the same requester.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign w_dec[gi] = (w_pick == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // 8-way 16-bit mux as a three-level tree of 2:1 stages driven by the
    // registered select bits.
    // ------------------------------------------------------------------
    assign w_lvl0[0] = in0;
    assign w_lvl0[1] = in1;
    assign w_lvl0[2] = in2;
    assign w_lvl0[3] = in3;
    assign w_lvl0[4] = in4;
    assign w_lvl0[5] = in5;
    assign w_lvl0[6] = in6;
    assign w_lvl0[7] = in7;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mux_l1
            assign w_lvl1[gi] = r_sel[0] ? w_lvl0[2*gi+1] : w_lvl0[2*gi];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_mux_l2
            assign w_lvl2[gi] = r_sel[1] ? w_lvl1[2*gi+1] : w_lvl1[2*gi];
        end
    endgenerate

    assign w_mux = r_sel[2] ? w_lvl2[1] : w_lvl2[0];

    // ------------------------------------------------------------------
    // Handshake and release qualifiers.
    // ------------------------------------------------------------------
    assign w_busy      = (r_state == BUSY);
    assign w_valid     = w_busy & req[r_sel];
    assign w_xfer      = w_valid & out_ready;
    assign w_count_inc = r_count + CW'(1);
    // A word tagged last that also fills the burst is a single release.
    assign w_final     = last[r_sel] | (w_count_inc == C_MAX);

    // ------------------------------------------------------------------
    // Control state machine.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 8'h00;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd7;        // requester 0 wins first after reset
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_gnt   <= w_dec;
                        r_sel   <= w_pick;
                        r_ptr   <= w_pick;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    if (!req[r_sel]) begin
                        // Owner withdrew: give up the bus, nothing moved.
                        r_state <= IDLE;
                        r_gnt   <= 8'h00;
                        r_count <= '0;
                    end else if (w_xfer) begin
                        if (w_final) begin
                            r_state <= IDLE;
                            r_gnt   <= 8'h00;
                            r_count <= '0;
                        end else begin
                            r_count <= w_count_inc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 8'h00;
                    r_count <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. out and out_valid are gated by state so an asynchronous
    // reset clears them at once.
    // ------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out       = w_busy ? w_mux : 16'h0000;
    assign out_valid = w_valid;

endmodule
`default_nettype wire
